bit_serial_alu_seq: RTL and testbench
=====================================

Name: bit_serial_alu_seq

Overview:
Multi-bit ALU controller that issues a WIDTH-bit AND/OR/ADD as a sequence of 1-bit slice operations. Operands are processed LSB-first, one bit per clock, through a single 1-bit slice, with the carry held in a flop between bits.
Sits between a requester (valid/ready command port) and a consumer (valid/ready result port).
Trades latency for area against a parallel WIDTH-bit ALU.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  command valid
in_ready  out  1  block can accept a command
op  in  2  00 AND, 01 OR, 10 ADD, 11 ZERO
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for ADD (ignored otherwise)
out_valid  out  1  result/cout valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
cout  out  1  carry-out for ADD; 0 for all other ops

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE; in_ready=1, out_valid=0, result=0, cout=0.
  - Shift registers, carry flop and bit counter clear to 0.
  - Any operation in flight is abandoned; no partial result is ever presented.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch a, b and op into registers; carry<=cin if op==ADD, else 0; count<=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the slice computes on a_sh[0], b_sh[0], carry:
    - res_bit: AND->a&b; OR->a|b; ADD->a^b^carry; ZERO->0.
    - c_next: ADD->majority(a,b,carry); otherwise 0.
  - Each edge: a_sh and b_sh shift right; res_sh shifts right with res_bit entering at bit WIDTH-1; carry<=c_next; count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE.
  - Exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1; result=res_sh; cout=carry.
  - Both hold stable until out_ready is sampled high; then go to IDLE.
  - result/cout keep their value after the handshake until the next command completes.
- Latency: command accepted at edge E gives out_valid=1 after edge E+WIDTH.
- Minimum command spacing is WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE handshake, IDLE).
- in_valid and operand changes are ignored while in_ready=0.
- The block holds no command queue.
- ADD arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Bit counter width is $clog2(WIDTH); the counter never wraps within a command.
- out_ready while not in DONE has no effect.

Decomposition:
- Package serial_alu_pkg holds:
  - op encoding constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_ZERO=2'b11;
  - state enum {IDLE, RUN, DONE}.
- Sub-module alu_bit_slice is natural: purely combinational (a, b, carry, op) -> (res_bit, c_next), so it can be unit-tested exhaustively on its 32 input combinations.
- Sequencing, shift registers and handshakes stay in the top module.

Test Plan:
WIDTH=8 unless noted.

1. Reset, then ADD a=0x5A b=0x3C cin=0 -> result=0x96, cout=0. out_valid rises exactly 8 cycles after acceptance, with in_ready=0 throughout.
2. ADD a=0xFF b=0x01 cin=0 -> result=0x00, cout=1. Then ADD a=0xFF b=0x00 cin=1 -> result=0x00, cout=1. Then ADD a=0x00 b=0x00 cin=1 -> result=0x01, cout=0.
3. AND a=0xF0 b=0x3C -> 0x30, cout=0. OR with the same operands -> 0xFC, cout=0. ZERO a=0xFF b=0xFF cin=1 -> 0x00, cout=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result/cout stay stable, in_ready=0, no command accepted. Raising out_ready gives IDLE on the next cycle.
5. Assert rst after the 3rd RUN cycle of ADD 0x5A+0x3C -> out_valid=0, result=0x00, cout=0, in_ready=1 immediately. A following AND 0xAA&0x0F -> 0x0A.
6. Back-to-back commands with in_valid and out_ready held high; repeat with WIDTH=2 (ADD 2'b11+2'b01 cin=0 -> 2'b00, cout=1) -> each command completes in WIDTH+2 cycles with correct results and no dropped or duplicated out_valid.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op encodings and FSM state type shared by the bit-serial ALU.
package serial_alu_pkg;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bit_serial_alu_seq_slice.sv
// alu_bit_slice: combinational 1-bit AND/OR/ADD/ZERO slice with carry.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry,
  input  logic [1:0] op,
  output logic       res_bit,
  output logic       c_next
);
  always_comb begin
    res_bit = op == OP_AND ? a & b :
              op == OP_OR  ? a | b :
              op == OP_ADD ? a ^ b ^ carry : 1'b0;
    c_next  = op == OP_ADD ? (a & b) | (a & carry) | (b & carry) : 1'b0;
  end
endmodule

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: WIDTH-bit AND/OR/ADD computed LSB-first through one bit slice.
module bit_serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d, cout_q, cout_d;
  logic             res_bit, c_next;
  alu_bit_slice u_slice (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .carry  (carry_q),
    .op     (op_q),
    .res_bit(res_bit),
    .c_next (c_next)
  );
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    if (state_q == IDLE && in_valid) begin
      a_d        = a;
      b_d        = b;
      op_d       = op;
      carry_d    = (op == OP_ADD) & cin;
      cnt_d      = '0;
      state_d    = RUN;
      in_ready_d = 1'b0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {res_bit, res_q[WIDTH-1:1]};
      carry_d = c_next;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = res_d;
        cout_d      = c_next;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: directed and random checks of the bit-serial ALU against a behavioural model.
module tb_bit_serial_alu_seq;
  import serial_alu_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0, cout;
  logic [1:0] op = '0;
  logic [W-1:0] a = '0, b = '0, result;
  logic iv2 = 0, ir2, ci2 = 0, ov2, or2 = 0, co2;
  logic [1:0] op2 = '0, a2 = '0, b2 = '0, r2;
  int vectors = 0, miscompares = 0;
  bit chk_en = 0;
  bit m_idle = 1, m_done = 0;
  int m_left = 0;
  logic [W:0] m_pend = '0, m_out = '0;
  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout)
  );
  bit_serial_alu_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op(op2), .a(a2), .b(b2),
    .cin(ci2), .out_valid(ov2), .out_ready(or2), .result(r2), .cout(co2)
  );
  function automatic logic [W:0] calc(input logic [1:0] o, input logic [W-1:0] x, y, input logic c);
    case (o)
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_ADD:  return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
      default: return '0;
    endcase
  endfunction
  function automatic logic [2:0] calc2(input logic [1:0] o, input logic [1:0] x, y, input logic c);
    case (o)
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_ADD:  return 3'(x) + 3'(y) + 3'(c);
      default: return '0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Transaction-level model: a command occupies the block for W cycles, then waits for acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1; m_done <= 0; m_left <= 0; m_out <= '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_pend <= calc(op, a, b, cin); m_left <= W; m_idle <= 0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1; m_out <= m_pend;
      end
    end else if (m_done && out_ready) begin
      m_done <= 0; m_idle <= 1;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_idle));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      chk("result", 32'(result), 32'(m_out[W-1:0]));
      chk("cout", 32'(cout), 32'(m_out[W]));
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask
  task automatic send(input logic [1:0] o, input logic [W-1:0] x, y, input logic c, input logic [W:0] exp);
    int n = 0;
    wait_idle();
    in_valid = 1; op = o; a = x; b = y; cin = c;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    chk("latency", 32'(n), 32'(W));
    chk("lit_result", 32'(result), 32'(exp[W-1:0]));
    chk("lit_cout", 32'(cout), 32'(exp[W]));
  endtask
  task automatic ack();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("ack_idle", 32'(in_ready), 32'd1);
  endtask
  initial begin
    int cnt;
    logic [2:0] e2;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 0;
    chk_en = 1;
    send(OP_ADD, 8'h5A, 8'h3C, 1'b0, 9'h096); ack();
    send(OP_ADD, 8'hFF, 8'h01, 1'b0, 9'h100); ack();
    send(OP_ADD, 8'hFF, 8'h00, 1'b1, 9'h100); ack();
    send(OP_ADD, 8'h00, 8'h00, 1'b1, 9'h001); ack();
    send(OP_AND, 8'hF0, 8'h3C, 1'b0, 9'h030); ack();
    send(OP_OR,  8'hF0, 8'h3C, 1'b1, 9'h0FC); ack();
    send(OP_ZERO, 8'hFF, 8'hFF, 1'b1, 9'h000); ack();
    send(OP_ADD, 8'hC3, 8'h81, 1'b1, 9'h145);
    repeat (5) begin
      in_valid = 1; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      @(negedge clk);
      chk("bp_result", 32'(result), 32'h45);
      chk("bp_cout", 32'(cout), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 0;
    ack();
    wait_idle();
    in_valid = 1; op = OP_ADD; a = 8'h5A; b = 8'h3C; cin = 0;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst = 0;
    @(negedge clk);
    send(OP_AND, 8'hAA, 8'h0F, 1'b0, 9'h00A); ack();
    wait_idle();
    cnt = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      a = W'($urandom); b = W'($urandom); op = 2'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (out_valid) cnt++;
    end
    in_valid = 0; out_ready = 0;
    chk("b2b_count", 32'(cnt), 32'd10);
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
      a = W'($urandom); b = W'($urandom); op = 2'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    repeat (12) @(negedge clk);
    out_ready = 0;
    iv2 = 1; or2 = 1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        op2 = OP_ADD; a2 = 2'b11; b2 = 2'b01; ci2 = 0;
      end else begin
        op2 = 2'($urandom); a2 = 2'($urandom); b2 = 2'($urandom); ci2 = 1'($urandom);
      end
      e2 = calc2(op2, a2, b2, ci2);
      @(negedge clk);
      chk("w2_run_in_ready", 32'(ir2), 32'd0);
      chk("w2_run_ov0", 32'(ov2), 32'd0);
      @(negedge clk);
      chk("w2_run_ov1", 32'(ov2), 32'd0);
      @(negedge clk);
      chk("w2_done_ov", 32'(ov2), 32'd1);
      chk("w2_result", 32'(r2), 32'(e2[1:0]));
      chk("w2_cout", 32'(co2), 32'(e2[2]));
      if (k == 0) chk("w2_lit", 32'({co2, r2}), 32'b100);
      @(negedge clk);
      chk("w2_idle_ov", 32'(ov2), 32'd0);
      chk("w2_idle_ir", 32'(ir2), 32'd1);
    end
    iv2 = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
